// File: rtl/prio_enc_rr.sv
// Priority encoder with registered grant, valid/ready handshake and
// fixed-priority or round-robin arbitration.
//
// Parameters:
//   N : number of request inputs (2..64)
//   W : index width, derived as $clog2(N)
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in         in   N-bit level-sensitive request vector
//   mode       in   0 = fixed (highest index wins), 1 = round-robin
//   out        out  W-bit granted index (registered)
//   out_valid  out  grant valid (registered)
//   out_ready  in   consumer accepts grant when out_valid && out_ready
//   out_onehot out  N-bit one-hot of out, only when PRIO_ENC_ONEHOT_EN
//                   is defined
module prio_enc_rr #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    input  logic         mode,
    output logic [W-1:0] out,
    output logic         out_valid,
`ifdef PRIO_ENC_ONEHOT_EN
    output logic [N-1:0] out_onehot,
`endif
    input  logic         out_ready
);

    logic [W-1:0] out_q, out_d;
    logic         valid_q, valid_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic [W-1:0] fx_sel;
    logic [W-1:0] rr_sel;
    logic [W-1:0] sel;
    logic         any_req;
    logic         load;

    // Index k steps below ptr, wrapping modulo N (not 2^W).
    function automatic logic [W-1:0] rr_idx(
        input logic [W-1:0] ptr,
        input int           k
    );
        int p;
        p = int'(ptr) - k;
        if (p < 0) p = p + N;
        return p[W-1:0];
    endfunction

    assign any_req = |in;
    assign load    = !valid_q || out_ready;

    // Fixed priority: later (higher) indices overwrite earlier ones.
    always_comb begin
        fx_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (in[i]) fx_sel = W'(i);
        end
    end

    // Round-robin: scan from the farthest position back toward ptr-1
    // so the nearest set bit below ptr (with wrap) wins; ptr itself
    // (k = N) is the last resort.
    always_comb begin
        rr_sel = '0;
        for (int k = N; k >= 1; k--) begin
            if (in[rr_idx(ptr_q, k)]) rr_sel = rr_idx(ptr_q, k);
        end
    end

    assign sel = mode ? rr_sel : fx_sel;

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = any_req;
            out_d   = any_req ? sel : '0;
            if (any_req && mode) ptr_d = sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

`ifdef PRIO_ENC_ONEHOT_EN
    logic [N-1:0] oh_q, oh_d;
    logic [N-1:0] oh_one;

    assign oh_one = {{(N-1){1'b0}}, 1'b1};

    always_comb begin
        oh_d = oh_q;
        if (load) oh_d = any_req ? (oh_one << sel) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) oh_q <= '0;
        else        oh_q <= oh_d;
    end

    assign out_onehot = oh_q;
`endif

endmodule
